// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if: UART byte-stream and memory-bus signals of the UART bus master.
//   master modport : the bus master side (drives tx_*, bus_req, mem_addr/wdata/wmask/rstrb).
//   slave modport  : the environment side (UART rx/tx, arbiter, memory).
// UART   : rx_data/rx_valid in, tx_data/tx_start out, tx_busy in.
// Bus    : bus_req/bus_gnt arbitration, mem_* FemtoRV32-style word access.
interface uart_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        input  rx_data, rx_valid, tx_busy, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
        output tx_data, tx_start, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
        input  tx_data, tx_start, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );
endinterface

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-driven single-word initiator for the FemtoRV32 memory bus.
// Commands (little-endian fields):
//   'W' a0 a1 a2 a3 d0 d1 d2 d3 -> word write, reply 0x06
//   'R' a0 a1 a2 a3             -> word read, reply 4 data bytes LSB first
//   anything else or misaligned -> reply 0x15
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : uart_bus_master_if.master (UART bytes + arbitrated memory bus)
//   busy        : high in every state except idle
module uart_bus_master #(
    parameter int unsigned IDLE_TIMEOUT = 2600000
) (
    input  logic                     clk,
    input  logic                     resetn,
    uart_bus_master_if.master        bus,
    output logic                     busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StData, StReq, StWrStb, StWrWait, StRdStb, StRdWait, StTx, StTxWait
    } state_e;

    localparam logic [7:0]  CmdWrite    = 8'h57;
    localparam logic [7:0]  CmdRead     = 8'h52;
    localparam logic [7:0]  ReplyAck    = 8'h06;
    localparam logic [7:0]  ReplyNak    = 8'h15;
    localparam logic [31:0] TimeoutLast = 32'(IDLE_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] reply_q, reply_d;   // byte on the wire is always reply_q[7:0]
    logic [1:0]  tx_idx_q, tx_idx_d;
    logic [1:0]  tx_last_q, tx_last_d;
    logic        tx_guard_q, tx_guard_d; // masks tx_busy for the first TX_WAIT cycle
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        tx_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            reply_q    <= '0;
            tx_idx_q   <= '0;
            tx_last_q  <= '0;
            tx_guard_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            reply_q    <= reply_d;
            tx_idx_q   <= tx_idx_d;
            tx_last_q  <= tx_last_d;
            tx_guard_q <= tx_guard_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        reply_d    = reply_q;
        tx_idx_d   = tx_idx_q;
        tx_last_d  = tx_last_q;
        tx_guard_d = 1'b0;
        idle_cnt_d = '0;
        tx_start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    byte_cnt_d = '0;
                    if (bus.rx_data == CmdWrite || bus.rx_data == CmdRead) begin
                        is_wr_d = (bus.rx_data == CmdWrite);
                        state_d = StAddr;
                    end else begin
                        reply_d   = {24'h0, ReplyNak};
                        tx_idx_d  = '0;
                        tx_last_d = '0;
                        state_d   = StTx;
                    end
                end
            end
            StAddr, StData: begin
                if (bus.rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Shift in from the top so four LSB-first bytes land in place.
                    if (state_q == StAddr) begin
                        addr_d = {bus.rx_data, addr_q[31:8]};
                    end else begin
                        wdata_d = {bus.rx_data, wdata_q[31:8]};
                    end
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        if (state_q == StData) begin
                            state_d = StReq;
                        end else if (addr_d[1:0] != 2'b00) begin
                            reply_d   = {24'h0, ReplyNak};
                            tx_idx_d  = '0;
                            tx_last_d = '0;
                            state_d   = StTx;
                        end else begin
                            state_d = is_wr_q ? StData : StReq;
                        end
                    end
                end else if (idle_cnt_q >= TimeoutLast) begin
                    // Abandon the partial command without a reply.
                    byte_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end
            StReq: begin
                if (bus.bus_gnt) begin
                    state_d = is_wr_q ? StWrStb : StRdStb;
                end
            end
            StWrStb: state_d = StWrWait;
            StWrWait: begin
                if (!bus.mem_wbusy) begin
                    reply_d   = {24'h0, ReplyAck};
                    tx_idx_d  = '0;
                    tx_last_d = '0;
                    state_d   = StTx;
                end
            end
            StRdStb: state_d = StRdWait;
            StRdWait: begin
                if (!bus.mem_rbusy) begin
                    reply_d   = bus.mem_rdata;
                    tx_idx_d  = '0;
                    tx_last_d = 2'd3;
                    state_d   = StTx;
                end
            end
            StTx: begin
                if (!bus.tx_busy) begin
                    tx_start   = 1'b1;
                    tx_guard_d = 1'b1;
                    state_d    = StTxWait;
                end
            end
            StTxWait: begin
                if (!tx_guard_q && !bus.tx_busy) begin
                    if (tx_idx_q == tx_last_q) begin
                        state_d = StIdle;
                    end else begin
                        tx_idx_d = tx_idx_q + 2'd1;
                        reply_d  = {8'h00, reply_q[31:8]};
                        state_d  = StTx;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are zero while not owning the bus so they can be OR-ed with the CPU's.
    always_comb begin
        bus.bus_req = (state_q == StReq)   || (state_q == StWrStb) || (state_q == StWrWait) ||
                      (state_q == StRdStb) || (state_q == StRdWait);
        bus.mem_addr  = bus.bus_req ? addr_q  : 32'h0;
        bus.mem_wdata = bus.bus_req ? wdata_q : 32'h0;
        bus.mem_wmask = (state_q == StWrStb) ? 4'hF : 4'h0;
        bus.mem_rstrb = (state_q == StRdStb);
        bus.tx_start  = tx_start;
        bus.tx_data   = (state_q == StTx) ? reply_q[7:0] : 8'h00;
        busy          = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master (IDLE_TIMEOUT = 16).
module tb_uart_bus_master;
    logic clk = 1'b0;
    logic resetn;
    logic busy;

    always #5 clk = ~clk;

    uart_bus_master_if bus_if ();

    uart_bus_master #(.IDLE_TIMEOUT(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if),
        .busy   (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    logic [7:0]  txq[$];
    int          wmask_cnt, bad_mask, rstrb_cnt, breq_cycles, stable_err, txreq_err, txbusy_err;
    logic [31:0] wr_addr, wr_data, rd_addr, hold_addr, hold_data;
    logic        hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        step();
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        step();
    endtask

    task automatic wait_idle(input int max, input string tag);
        for (int i = 0; i < max && busy; i++) step();
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic clear_mon();
        txq.delete();
        wmask_cnt = 0; bad_mask = 0; rstrb_cnt = 0; breq_cycles = 0;
        stable_err = 0; txreq_err = 0; txbusy_err = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
    endtask

    // Bus monitor, sampled mid-cycle.
    initial begin
        hold = 1'b0; hold_addr = '0; hold_data = '0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (bus_if.bus_req) breq_cycles++;
                if (bus_if.mem_wmask != 4'h0) begin
                    wmask_cnt++;
                    if (bus_if.mem_wmask != 4'hF) bad_mask++;
                    wr_addr = bus_if.mem_addr; wr_data = bus_if.mem_wdata;
                    hold_addr = bus_if.mem_addr; hold_data = bus_if.mem_wdata; hold = 1'b1;
                end else if (bus_if.mem_rstrb) begin
                    rstrb_cnt++;
                    rd_addr = bus_if.mem_addr;
                    hold_addr = bus_if.mem_addr; hold_data = bus_if.mem_wdata; hold = 1'b1;
                end else if (hold && bus_if.bus_req) begin
                    if (bus_if.mem_addr != hold_addr || bus_if.mem_wdata != hold_data)
                        stable_err++;
                end
                if (!bus_if.bus_req) hold = 1'b0;
                if (bus_if.tx_start && bus_if.bus_req) txreq_err++;
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Transmitter model: busy for 3 cycles starting in the cycle after tx_start.
    initial begin
        bus_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && bus_if.tx_start) begin
                if (bus_if.tx_busy) txbusy_err++;
                txq.push_back(bus_if.tx_data);
                #6;
                bus_if.tx_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                bus_if.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        resetn           = 1'b0;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_data   = 8'h00;
        bus_if.bus_gnt   = 1'b1;
        bus_if.mem_rdata = 32'h0;
        bus_if.mem_rbusy = 1'b0;
        bus_if.mem_wbusy = 1'b0;
        clear_mon();
        step(); step();

        // Reset state
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_busreq", {31'b0, bus_if.bus_req}, 32'd0);
        check("rst_txs",    {31'b0, bus_if.tx_start}, 32'd0);
        check("rst_txdata", {24'b0, bus_if.tx_data}, 32'd0);
        check("rst_addr",   bus_if.mem_addr, 32'd0);
        check("rst_wmask",  {28'b0, bus_if.mem_wmask}, 32'd0);
        check("rst_rstrb",  {31'b0, bus_if.mem_rstrb}, 32'd0);
        resetn = 1'b1;
        step();

        // Write with grant present and zero-busy memory
        clear_mon();
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_idle(200, "wr_done");
        check("wr_wmask_cnt", 32'(wmask_cnt), 32'd1);
        check("wr_bad_mask",  32'(bad_mask), 32'd0);
        check("wr_addr",      wr_addr, 32'h0000_0100);
        check("wr_data",      wr_data, 32'hDEAD_BEEF);
        check("wr_breq_cyc",  32'(breq_cycles), 32'd3);
        check("wr_tx_len",    32'(txq.size()), 32'd1);
        check("wr_tx_ack",    {24'b0, txq[0]}, 32'h06);
        check("wr_txreq",     32'(txreq_err), 32'd0);

        // Read with two busy cycles after rstrb
        clear_mon();
        bus_if.mem_rdata = 32'hAAAA_5555;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 20 && !bus_if.mem_rstrb; i++) step();
        check("rd_stb_seen", {31'b0, bus_if.mem_rstrb}, 32'd1);
        bus_if.mem_rbusy = 1'b1;
        step(); step();
        bus_if.mem_rbusy = 1'b0;
        bus_if.mem_rdata = 32'h1234_5678;
        wait_idle(200, "rd_done");
        check("rd_rstrb_cnt", 32'(rstrb_cnt), 32'd1);
        check("rd_addr",      rd_addr, 32'h0000_0100);
        check("rd_tx_len",    32'(txq.size()), 32'd4);
        check("rd_tx_b0",     {24'b0, txq[0]}, 32'h78);
        check("rd_tx_b1",     {24'b0, txq[1]}, 32'h56);
        check("rd_tx_b2",     {24'b0, txq[2]}, 32'h34);
        check("rd_tx_b3",     {24'b0, txq[3]}, 32'h12);
        check("rd_txbusy",    32'(txbusy_err), 32'd0);
        check("rd_txreq",     32'(txreq_err), 32'd0);

        // Misaligned read address
        clear_mon();
        send_byte(8'h52);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_idle(200, "mis_done");
        check("mis_tx_len", 32'(txq.size()), 32'd1);
        check("mis_tx_nak", {24'b0, txq[0]}, 32'h15);
        check("mis_rstrb",  32'(rstrb_cnt), 32'd0);
        check("mis_wmask",  32'(wmask_cnt), 32'd0);
        check("mis_breq",   32'(breq_cycles), 32'd0);

        // Unknown command
        clear_mon();
        send_byte(8'h41);
        wait_idle(200, "unk_done");
        check("unk_tx_len", 32'(txq.size()), 32'd1);
        check("unk_tx_nak", {24'b0, txq[0]}, 32'h15);

        // Delayed grant, write busy
        clear_mon();
        bus_if.bus_gnt = 1'b0;
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        for (int i = 0; i < 20 && !bus_if.bus_req; i++) step();
        check("arb_req_seen", {31'b0, bus_if.bus_req}, 32'd1);
        repeat (5) step();
        check("arb_no_wmask", 32'(wmask_cnt), 32'd0);
        bus_if.bus_gnt = 1'b1;
        for (int i = 0; i < 20 && bus_if.mem_wmask == 4'h0; i++) step();
        check("arb_wmask_seen", {28'b0, bus_if.mem_wmask}, 32'hF);
        bus_if.mem_wbusy = 1'b1;
        step(); step(); step();
        check("arb_req_held", {31'b0, bus_if.bus_req}, 32'd1);
        bus_if.mem_wbusy = 1'b0;
        wait_idle(200, "arb_done");
        check("arb_wmask_cnt", 32'(wmask_cnt), 32'd1);
        check("arb_addr",      wr_addr, 32'h0000_0200);
        check("arb_data",      wr_data, 32'h1122_3344);
        check("arb_stable",    32'(stable_err), 32'd0);
        check("arb_tx_ack",    {24'b0, txq[0]}, 32'h06);

        // Timeout on a partial command: transition at the end of the 16th silent cycle
        clear_mon();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (14) step();
        check("to_still_busy", {31'b0, busy}, 32'd1);
        step();
        check("to_idle", {31'b0, busy}, 32'd0);
        check("to_no_tx", 32'(txq.size()), 32'd0);
        check("to_no_req", 32'(breq_cycles), 32'd0);
        bus_if.mem_rdata = 32'hCAFE_F00D;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        wait_idle(200, "to_rd_done");
        check("to_rd_rstrb", 32'(rstrb_cnt), 32'd1);
        check("to_rd_len",   32'(txq.size()), 32'd4);
        check("to_rd_b0",    {24'b0, txq[0]}, 32'h0D);
        check("to_rd_b3",    {24'b0, txq[3]}, 32'hCA);

        // Reset asserted during WR_WAIT
        clear_mon();
        bus_if.mem_wbusy = 1'b1;
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 20 && bus_if.mem_wmask == 4'h0; i++) step();
        check("rm_wmask_seen", {28'b0, bus_if.mem_wmask}, 32'hF);
        step(); step();
        check("rm_in_wait", {31'b0, bus_if.bus_req}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rm_busreq", {31'b0, bus_if.bus_req}, 32'd0);
        check("rm_addr",   bus_if.mem_addr, 32'd0);
        check("rm_wdata",  bus_if.mem_wdata, 32'd0);
        check("rm_wmask",  {28'b0, bus_if.mem_wmask}, 32'd0);
        check("rm_busy",   {31'b0, busy}, 32'd0);
        check("rm_txs",    {31'b0, bus_if.tx_start}, 32'd0);
        step();
        bus_if.mem_wbusy = 1'b0;
        resetn = 1'b1;
        clear_mon();
        step(); step(); step();
        check("rm_no_stale", 32'(txq.size()), 32'd0);
        bus_if.mem_rdata = 32'h0102_0304;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        wait_idle(200, "rm_rd_done");
        check("rm_rd_len", 32'(txq.size()), 32'd4);
        check("rm_rd_b0",  {24'b0, txq[0]}, 32'h04);
        check("rm_rd_b3",  {24'b0, txq[3]}, 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

UART-driven initiator for the FemtoRV32 memory bus. It turns a byte command stream from a UART receiver into single-word bus reads and writes. It returns acknowledge or read data bytes to a UART transmitter. It sits beside the CPU in the SoC as a second bus initiator (program loader / debug port) and accesses RAM and all memory-mapped peripherals through an external request/grant arbiter.

## Interface
- IDLE_TIMEOUT, default 2600000: cycles of rx silence that abort a partially received command (100 ms at 26 MHz).
- clk  in  1  system clock.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle strobe, launch tx_data.
- tx_busy  in  1  transmitter busy.
- bus_req  out  1  request bus ownership.
- bus_gnt  in  1  arbiter grant; CPU is held off while high.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte write enables.
- mem_rstrb  out  1  read strobe.
- mem_rdata  in  32  read data.
- mem_rbusy  in  1  read not complete.
- mem_wbusy  in  1  write not complete.
- busy  out  1  high in every state except IDLE.

## Operation
- Commands; multi-byte fields are little-endian, LSB first:
  - 'W' (0x57): 4 address bytes, then 4 data bytes. Performs a word write, then replies ACK 0x06.
  - 'R' (0x52): 4 address bytes. Performs a word read, then replies with 4 data bytes, LSB first.
  - Any other first byte: reply NAK 0x15, return to IDLE.
- Alignment: if the assembled address has addr[1:0] != 0, reply NAK 0x15 and make no bus access.
- FSM states: IDLE, ADDR (byte count 0..3), DATA (byte count 0..3), REQ, WR_STB, WR_WAIT, RD_STB, RD_WAIT, TX, TX_WAIT.
  - IDLE: on rx_valid, 'W' or 'R' goes to ADDR; any other byte loads NAK and goes to TX.
  - ADDR: collects 4 bytes. Then a misaligned address goes to TX (NAK); a 'W' command goes to DATA; an 'R' command goes to REQ.
  - DATA: collects 4 bytes, then goes to REQ.
  - REQ: bus_req=1; wait for bus_gnt=1. Then a write goes to WR_STB and a read goes to RD_STB.
  - WR_STB: mem_wmask=4'b1111 for exactly one cycle, then WR_WAIT.
  - WR_WAIT: wait while mem_wbusy=1; when low, load ACK and go to TX.
  - RD_STB: mem_rstrb=1 for exactly one cycle, then RD_WAIT.
  - RD_WAIT: on the first cycle with mem_rbusy=0, capture mem_rdata into a 4-byte reply and go to TX.
  - TX: when tx_busy=0, pulse tx_start for one cycle with tx_data = current byte, then go to TX_WAIT.
  - TX_WAIT: ignore tx_busy for 1 cycle, then wait for tx_busy=0. Then send the next byte via TX, or go to IDLE after the last byte (1 byte for ACK/NAK, 4 for a read).
- Bus ownership:
  - bus_req is high from REQ through WR_WAIT/RD_WAIT and drops on entry to TX.
  - mem_addr and mem_wdata hold stable from WR_STB/RD_STB until the access completes.
  - mem_addr, mem_wdata, mem_wmask and mem_rstrb are 0 whenever bus_req=0, so the SoC may OR them with CPU outputs.
- rx_valid in REQ..TX_WAIT: byte dropped, no state change.
- Timeout: an idle counter clears on each rx_valid in ADDR/DATA. When it reaches IDLE_TIMEOUT, the FSM returns silently to IDLE with no reply. The counter does not run in other states.
- bus_gnt never asserting: the FSM waits in REQ indefinitely (no timeout).

## Timing
- Reset: every output is 0, FSM is IDLE, byte counters and timeout counter are 0. An assertion mid-transfer aborts immediately, including releasing bus_req in the same cycle.
- Bus access latency, grant present:
  - Write: wmask asserts 1 cycle after the cycle in which REQ sees bus_gnt=1.
  - Read: rstrb asserts 1 cycle after the cycle in which REQ sees bus_gnt=1; the earliest rdata sample is the cycle after rstrb.
- Zero-busy write: bus_req is high for 3 cycles (REQ, WR_STB, WR_WAIT).
- Reply: tx_start asserts 1 cycle after entering TX, if tx_busy=0.

## Test plan
- Write: rx 57 00 01 00 00 EF BE AD DE, with bus_gnt=1, mem_wbusy=0 -> one cycle of mem_wmask=1111, mem_addr=0x00000100, mem_wdata=0xDEADBEEF; tx 06; bus_req is low during tx.
- Read: rx 52 00 01 00 00, mem_rdata=0x12345678, mem_rbusy high 2 cycles after rstrb -> single rstrb pulse, addr 0x00000100; tx 78 56 34 12 in order, each tx_start only when tx_busy=0.
- Errors: rx 52 02 00 00 00 -> tx 15, no rstrb or wmask; rx 41 -> tx 15, back in IDLE.
- Arbitration: bus_gnt delayed 5 cycles after bus_req and mem_wbusy held 3 cycles -> wmask waits for grant, asserts once, addr/wdata stable until wbusy falls.
- Timeout with IDLE_TIMEOUT=16: rx 57 00 01, then 16 silent cycles -> IDLE, no tx, busy=0. Subsequent rx 52 00 01 00 00 performs a normal read.
- Reset mid-op: assert resetn=0 during WR_WAIT -> all outputs 0 asynchronously; after release, a fresh 'R' command works and no stale reply is sent.
